// File: rtl/div_ctrl_pkg.sv
// Shared constants and state type for the EX-stage divider sequencing controller.
package div_ctrl_pkg;

  localparam int unsigned WORD_W           = 32;
  localparam int unsigned DIV_RESULT_W     = 64;
  localparam int unsigned ABORT_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE,
    ABORT
  } state_t;

endpackage

// File: rtl/div_ctrl.sv
// Sequences DIV/DIVU between EX and the iterative divider: operand latch,
// start/annul handshake, pipeline stall and a single HI/LO write strobe.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int unsigned ABORT_CYCLES = ABORT_CYCLES_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ex_div_valid_i,
  input  logic                    ex_div_signed_i,
  input  logic [WORD_W-1:0]       ex_op_a_i,
  input  logic [WORD_W-1:0]       ex_op_b_i,
  input  logic                    ex_hold_i,
  input  logic                    flush_i,
  output logic                    stall_req_o,
  output logic                    div_start_o,
  output logic                    div_annul_o,
  output logic                    div_signed_o,
  output logic [WORD_W-1:0]       div_op_a_o,
  output logic [WORD_W-1:0]       div_op_b_o,
  input  logic [DIV_RESULT_W-1:0] div_result_i,
  input  logic                    div_ready_i,
  output logic                    hilo_we_o,
  output logic [WORD_W-1:0]       hi_o,
  output logic [WORD_W-1:0]       lo_o,
  output logic                    busy_o
);

  localparam int unsigned CNT_W = (ABORT_CYCLES > 1) ? $clog2(ABORT_CYCLES + 1) : 1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] abort_cnt;
  logic             first_done;
  logic             accept, capture, abort;

  always_comb begin
    accept  = (state == IDLE) && ex_div_valid_i && !flush_i;
    abort   = (state == BUSY) && flush_i;
    capture = (state == BUSY) && !flush_i && div_ready_i;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (accept) state_nxt = BUSY;
      BUSY: begin
        if (flush_i)          state_nxt = ABORT;
        else if (div_ready_i) state_nxt = DONE;
      end
      // The same instruction is still in EX while DONE, so never re-accept here.
      DONE:  if (flush_i || !ex_hold_i) state_nxt = IDLE;
      ABORT: if (abort_cnt <= CNT_W'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are only written on acceptance so the divider sees them stable
  // through its final sign-fixup cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_signed_o <= 1'b0;
      div_op_a_o   <= '0;
      div_op_b_o   <= '0;
      hi_o         <= '0;
      lo_o         <= '0;
      abort_cnt    <= '0;
      first_done   <= 1'b0;
    end else begin
      if (accept) begin
        div_signed_o <= ex_div_signed_i;
        div_op_a_o   <= ex_op_a_i;
        div_op_b_o   <= ex_op_b_i;
      end
      if (capture) begin
        hi_o <= div_result_i[DIV_RESULT_W-1:WORD_W];
        lo_o <= div_result_i[WORD_W-1:0];
      end
      if (abort)
        abort_cnt <= CNT_W'(ABORT_CYCLES);
      else if ((state == ABORT) && (abort_cnt != '0))
        abort_cnt <= abort_cnt - CNT_W'(1);
      first_done <= capture;
    end
  end

  always_comb begin
    stall_req_o = 1'b0;
    div_start_o = 1'b0;
    div_annul_o = 1'b0;
    hilo_we_o   = 1'b0;
    busy_o      = (state != IDLE);
    unique case (state)
      IDLE: stall_req_o = ex_div_valid_i && !flush_i;
      BUSY: begin
        stall_req_o = 1'b1;
        div_start_o = !flush_i;
        div_annul_o = flush_i;
      end
      DONE:    hilo_we_o = first_done && !flush_i;
      ABORT:   ;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with a behavioural divider and result scoreboard.
module tb_div_ctrl;

  localparam int unsigned AC       = 2;
  localparam int          LAT_NORM = 34;
  localparam int          LAT_ZERO = 3;
  localparam int          STALL_N  = LAT_NORM + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_div_valid_i, ex_div_signed_i, ex_hold_i, flush_i;
  logic [31:0] ex_op_a_i, ex_op_b_i;
  logic        stall_req_o, div_start_o, div_annul_o, div_signed_o;
  logic [31:0] div_op_a_o, div_op_b_o;
  logic [63:0] div_result_i;
  logic        div_ready_i;
  logic        hilo_we_o, busy_o;
  logic [31:0] hi_o, lo_o;

  always #5 clk = ~clk;

  div_ctrl #(.ABORT_CYCLES(AC)) dut (
    .clk(clk), .rst(rst),
    .ex_div_valid_i(ex_div_valid_i), .ex_div_signed_i(ex_div_signed_i),
    .ex_op_a_i(ex_op_a_i), .ex_op_b_i(ex_op_b_i),
    .ex_hold_i(ex_hold_i), .flush_i(flush_i),
    .stall_req_o(stall_req_o), .div_start_o(div_start_o), .div_annul_o(div_annul_o),
    .div_signed_o(div_signed_o), .div_op_a_o(div_op_a_o), .div_op_b_o(div_op_b_o),
    .div_result_i(div_result_i), .div_ready_i(div_ready_i),
    .hilo_we_o(hilo_we_o), .hi_o(hi_o), .lo_o(lo_o), .busy_o(busy_o)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // MIPS-style division: truncating, divide-by-zero yields zero.
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    if (b == 32'd0) return '0;
    if (!s) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    sa = a;
    sb = b;
    return {32'(sa % sb), 32'(sa / sb)};
  endfunction

  // Divider model: result only valid in the ready cycle, computed from the
  // operands presented at that moment.
  int dcnt;
  always @(posedge clk) begin
    if (rst || div_annul_o || !div_start_o) dcnt <= 0;
    else if (dcnt < 100)                    dcnt <= dcnt + 1;
  end
  assign div_ready_i  = div_start_o && (dcnt == ((div_op_b_o == 32'd0) ? LAT_ZERO : LAT_NORM));
  assign div_result_i = div_ready_i ? ref_div(div_signed_o, div_op_a_o, div_op_b_o)
                                    : 64'hDEAD_BEEF_DEAD_BEEF;

  logic [63:0] exp_q[$];
  logic        cur_s;
  logic [31:0] cur_a, cur_b;
  int          we_total = 0;
  int          annul_total = 0;
  bit          armed = 1'b0;
  int          gap = 0;

  always @(negedge clk) begin
    logic [63:0] e;
    #3;
    if (!rst) begin
      if (div_start_o) begin
        chk("op_ab_stable", {div_op_a_o, div_op_b_o}, {cur_a, cur_b});
        chk("op_signed_stable", div_signed_o, cur_s);
      end
      if (div_annul_o) begin
        annul_total++;
        chk("annul_without_start", div_start_o, 1'b0);
        armed = 1'b1;
        gap = 0;
      end else if (armed && !div_start_o) begin
        gap++;
      end else if (armed && div_start_o) begin
        chk("abort_start_gap", gap >= int'(AC), 1'b1);
        armed = 1'b0;
      end
      if (hilo_we_o) begin
        we_total++;
        chk("we_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("hilo_scoreboard", {hi_o, lo_o}, e);
        end
      end
    end
  end

  task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b, input bit expect_wr);
    ex_div_signed_i = s;
    ex_op_a_i       = a;
    ex_op_b_i       = b;
    ex_div_valid_i  = 1'b1;
    cur_s = s;
    cur_a = a;
    cur_b = b;
    if (expect_wr) exp_q.push_back(ref_div(s, a, b));
  endtask

  task automatic finish_op(input string nm, input logic [31:0] ehi, input logic [31:0] elo,
                           input int hold, input int exp_stall);
    int stall_n, we_n, hold_act;
    #1;
    stall_n  = int'(stall_req_o);
    we_n     = 0;
    hold_act = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      #1;
      if (hilo_we_o) begin
        we_n = 1;
        break;
      end
      stall_n += int'(stall_req_o);
    end
    chk({nm, "_stall_cycles"}, stall_n, exp_stall);
    ex_hold_i = (hold > 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      #1;
      we_n     += int'(hilo_we_o);
      hold_act += int'(div_start_o) + int'(stall_req_o) + int'(!busy_o);
      if (i == hold - 1) ex_hold_i = 1'b0;
    end
    @(negedge clk);
    ex_div_valid_i = 1'b0;
    #1;
    chk({nm, "_we_pulses"}, we_n, 1);
    chk({nm, "_hold_quiet"}, hold_act, 0);
    chk({nm, "_idle_after"}, busy_o, 1'b0);
    chk({nm, "_hi"}, hi_o, ehi);
    chk({nm, "_lo"}, lo_o, elo);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ctrl"}, {stall_req_o, div_start_o, div_annul_o, div_signed_o, hilo_we_o, busy_o}, 6'b0);
    chk({nm, "_ops"}, {div_op_a_o, div_op_b_o}, 64'h0);
    chk({nm, "_hilo"}, {hi_o, lo_o}, 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    ex_div_valid_i = 1'b0; ex_div_signed_i = 1'b0; ex_hold_i = 1'b0; flush_i = 1'b0;
    ex_op_a_i = '0; ex_op_b_i = '0;
    cur_s = 1'b0; cur_a = '0; cur_b = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    launch(1'b0, 32'd100, 32'd7, 1'b1);
    finish_op("divu_100_7", 32'd2, 32'd14, 0, STALL_N);
    launch(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1);
    finish_op("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, STALL_N);
    launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    finish_op("div_ovf", 32'h0, 32'h8000_0000, 0, STALL_N);
    launch(1'b0, 32'd5, 32'd0, 1'b1);
    finish_op("div_by_zero", 32'h0, 32'h0, 0, LAT_ZERO + 2);

    // Flush mid-BUSY; the next op is presented during ABORT and must wait.
    launch(1'b0, 32'd1000, 32'd3, 1'b0);
    repeat (10) @(negedge clk);
    flush_i = 1'b1;
    #1;
    chk("flush_annul", div_annul_o, 1'b1);
    chk("flush_start_low", div_start_o, 1'b0);
    @(negedge clk);
    flush_i = 1'b0;
    launch(1'b0, 32'd9, 32'd3, 1'b1);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (stall_req_o) break;
      if (busy_o) n++;
      @(negedge clk);
    end
    chk("abort_cycles", n, AC);
    chk("abort_exit", stall_req_o, 1'b1);
    finish_op("divu_9_3", 32'd0, 32'd3, 0, STALL_N);

    launch(1'b0, 32'd17, 32'd5, 1'b1);
    finish_op("divu_hold", 32'd2, 32'd3, 5, STALL_N);
    launch(1'b0, 32'd20, 32'd6, 1'b1);
    finish_op("divu_20_6", 32'd2, 32'd3, 0, STALL_N);

    // Reset in the middle of BUSY abandons the op.
    launch(1'b0, 32'd77, 32'd4, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    ex_div_valid_i = 1'b0;
    @(negedge clk);
    #1;
    chk_zero("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    launch(1'b0, 32'd50, 32'd7, 1'b1);
    finish_op("divu_50_7", 32'd1, 32'd7, 0, STALL_N);

    // Flush in IDLE blocks acceptance.
    launch(1'b0, 32'd8, 32'd2, 1'b0);
    flush_i = 1'b1;
    #1;
    chk("idle_flush_no_stall", stall_req_o, 1'b0);
    @(negedge clk);
    #1;
    chk("idle_flush_no_accept", busy_o, 1'b0);
    flush_i = 1'b0;
    ex_div_valid_i = 1'b0;

    // Flush coinciding with the write cycle suppresses the write.
    @(negedge clk);
    launch(1'b0, 32'd40, 32'd5, 1'b0);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      #1;
      if (div_ready_i) break;
    end
    chk("done_flush_ready_seen", div_ready_i, 1'b1);
    @(negedge clk);
    flush_i = 1'b1;
    #1;
    chk("done_flush_no_we", hilo_we_o, 1'b0);
    chk("done_flush_in_done", busy_o, 1'b1);
    chk("done_flush_captured", {hi_o, lo_o}, {32'd0, 32'd8});
    @(negedge clk);
    flush_i = 1'b0;
    ex_div_valid_i = 1'b0;
    #1;
    chk("done_flush_idle", busy_o, 1'b0);

    repeat (3) @(negedge clk);
    chk("we_total", we_total, 8);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("annul_total", annul_total, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Sequencing controller between the EX stage and the iterative 32-bit divider (start/annul/ready protocol, 64-bit {remainder, quotient} result).
- Accepts a DIV/DIVU from EX and holds the divider's operands stable for the whole operation.
- Drives start, annul and pipeline stall; captures the result and pulses a HI/LO write.
- Handles flush mid-operation so a new divide never starts while the divider is still returning to free.

Parameters:
- ABORT_CYCLES, 2, cycles div_start_o is held low after an annul before a new op may start (covers the divider's by-zero→end→free path).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ex_div_valid_i  in  1  EX holds a DIV/DIVU
- ex_div_signed_i  in  1  1 = DIV, 0 = DIVU
- ex_op_a_i  in  32  dividend (rs)
- ex_op_b_i  in  32  divisor (rt)
- ex_hold_i  in  1  EX held by another stall source
- flush_i  in  1  exception/flush; kills the in-flight divide
- stall_req_o  out  1  stall request to pipeline control
- div_start_o  out  1  divider start (level)
- div_annul_o  out  1  divider annul
- div_signed_o  out  1  divider signed select
- div_op_a_o  out  32  divider dividend
- div_op_b_o  out  32  divider divisor
- div_result_i  in  64  divider result {remainder, quotient}
- div_ready_i  in  1  divider complete
- hilo_we_o  out  1  one-cycle HI/LO write strobe
- hi_o  out  32  remainder
- lo_o  out  32  quotient
- busy_o  out  1  controller not IDLE

Behaviour:
- Reset (synchronous, rst=1): state IDLE, abort counter 0. All outputs 0: stall_req_o, div_start_o, div_annul_o, div_signed_o, div_op_a_o, div_op_b_o, hilo_we_o, hi_o, lo_o, busy_o. Reset mid-operation abandons the op with no HI/LO write; the divider shares rst.
- Operand latch: signed, a and b are registered on acceptance. div_*_o are driven only from the latch, stable from acceptance until return to IDLE or ABORT. The divider re-reads operand signs in its final cycle, so this stability is mandatory.
- States:
  - IDLE: start=0, annul=0. If ex_div_valid_i & !flush_i: latch operands, go BUSY. stall_req_o = ex_div_valid_i & !flush_i (combinational, same cycle).
  - BUSY: start=1, stall_req_o=1.
    - If flush_i: annul=1, start=0, go ABORT, counter ← ABORT_CYCLES.
    - Else if div_ready_i: register hi_o ← result[63:32], lo_o ← result[31:0], go DONE.
  - DONE: start=0, stall_req_o=0, hilo_we_o=1 for exactly one cycle (only the first DONE cycle). Dropping start returns the divider to free.
    - Stay while ex_hold_i=1; go IDLE when ex_hold_i=0.
    - flush_i in DONE goes to IDLE. If flush_i coincides with the hilo_we_o cycle, suppress the write.
    - An op must not be re-accepted in DONE (same instruction still in EX).
  - ABORT: start=0, annul=0, stall_req_o=0, count down; go IDLE when counter reaches 1. New ops wait in IDLE, so they cannot start early.
- Latency: acceptance → div_start_o high next cycle. The divider needs about 35 cycles to ready; the controller must not depend on the exact count. Ready → hilo_we_o 1 cycle later.
- Divide by zero: no special case; the divider returns 0, so hi_o=lo_o=0 and the write still occurs.
- flush_i has priority over div_ready_i in the same BUSY cycle: abort, no write.
- flush_i in IDLE blocks acceptance.
- busy_o = state≠IDLE.

Decomposition:
- Shared package (cpu constants):
  - state enum {IDLE, BUSY, DONE, ABORT}
  - DIV_RESULT_W=64, WORD_W=32
  - ABORT_CYCLES default
- No sub-module. One FSM plus operand/result registers; the divider is instantiated by the parent.

Test Plan:
- DIVU 100/7 → stall_req_o high from acceptance until ready+1; lo=14, hi=2; hilo_we_o one pulse; div_op_a/b stable throughout.
- DIV 0xFFFFFFF9 (-7) / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- Divide by zero, a=5, b=0 → ready within about 4 cycles of start; hi=lo=0; one write pulse.
- flush_i 10 cycles into BUSY → div_annul_o one pulse, no hilo_we_o, start low ≥ABORT_CYCLES. A new DIVU 9/3 then yields lo=3, hi=0.
- ex_hold_i=1 for 5 cycles in DONE → single hilo_we_o, no restart. Then a back-to-back DIVU 20/6 yields lo=3, hi=2.
- rst mid-BUSY → all outputs 0 next cycle, IDLE; no write; the next op completes correctly.
